// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto one registered memory port, with a
// two-stage response pipeline. Define ARB_STARVE_GUARD_EN for the fetch anti-starvation counter.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_width,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_re,
  output logic        m_we,
  output logic [1:0]  m_width,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam logic [1:0] W_HALF = 2'd1;
  localparam logic [1:0] W_WORD = 2'd2;
  localparam logic [1:0] W_BAD  = 2'd3;
  localparam logic [3:0] LIMIT  = 4'(STARVE_LIMIT);

  typedef struct packed {
    logic        re;
    logic        we;
    logic [1:0]  width;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic        is_d;
    logic        err;
  } tag_t;

  typedef struct packed {
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
  } rsp_t;

  logic       i_gnt_c, d_gnt_c, starve_hit, d_mis;
  mem_cmd_t   cmd_d, cmd_q;
  tag_t       tag_d, tag_q;
  rsp_t       rsp_d, rsp_q;
  // [0]: access sitting on the memory port, [1]: response being presented
  logic [1:0] vld_pipe_d, vld_pipe_q;

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] cnt_d, cnt_q;

  assign starve_hit = (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (!i_req || i_gnt_c) cnt_d = 4'd0;
    else if (d_gnt_c)      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_limit;
  assign unused_limit = ^LIMIT;
  assign starve_hit   = 1'b0;
`endif

  // Data normally wins; the guard hands one slot to fetch once the limit is hit.
  always_comb begin
    i_gnt_c = 1'b0;
    d_gnt_c = 1'b0;
    if (!rst) begin
      if (i_req && d_req && starve_hit) i_gnt_c = 1'b1;
      else if (d_req)                   d_gnt_c = 1'b1;
      else if (i_req)                   i_gnt_c = 1'b1;
    end
  end

  assign i_gnt = i_gnt_c;
  assign d_gnt = d_gnt_c;

  always_comb begin
    d_mis = 1'b0;
    case (d_width)
      W_HALF:  d_mis = d_addr[0];
      W_WORD:  d_mis = (d_addr[1:0] != 2'b00);
      W_BAD:   d_mis = 1'b1;
      default: d_mis = 1'b0;
    endcase
  end

  // Stage 1: build the memory command for the granted requester.
  always_comb begin
    cmd_d         = '0;
    tag_d         = '0;
    vld_pipe_d[0] = i_gnt_c | d_gnt_c;
    if (i_gnt_c) begin
      cmd_d.re    = 1'b1;
      cmd_d.width = W_WORD;
      cmd_d.addr  = i_addr;
    end else if (d_gnt_c) begin
      tag_d.is_d = 1'b1;
      if (d_mis) begin
        tag_d.err = 1'b1;
      end else begin
        cmd_d.re    = ~d_we;
        cmd_d.we    = d_we;
        cmd_d.width = d_width;
        cmd_d.addr  = d_addr;
        cmd_d.wdata = d_we ? d_wdata : 32'h0;
      end
    end
  end

  // Stage 2: route captured read data (or ack/error) back to the owner.
  always_comb begin
    rsp_d         = '0;
    vld_pipe_d[1] = vld_pipe_q[0];
    if (vld_pipe_q[0]) begin
      if (tag_q.is_d) begin
        rsp_d.d_rvalid = 1'b1;
        rsp_d.d_err    = tag_q.err;
        rsp_d.d_rdata  = cmd_q.re ? m_rdata : 32'h0;
      end else begin
        rsp_d.i_rvalid = 1'b1;
        rsp_d.i_rdata  = m_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      tag_q      <= '0;
      rsp_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      rsp_q      <= rsp_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, including work already in flight.
  assign m_re     = cmd_q.re & ~rst;
  assign m_we     = cmd_q.we & ~rst;
  assign m_width  = rst ? 2'd0  : cmd_q.width;
  assign m_addr   = rst ? 32'h0 : cmd_q.addr;
  assign m_wdata  = rst ? 32'h0 : cmd_q.wdata;
  assign i_rvalid = rsp_q.i_rvalid & ~rst;
  assign i_rdata  = rst ? 32'h0 : rsp_q.i_rdata;
  assign d_rvalid = rsp_q.d_rvalid & ~rst;
  assign d_rdata  = rst ? 32'h0 : rsp_q.d_rdata;
  assign d_err    = rsp_q.d_err & ~rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch/data paths, misalignment,
// priority/starvation pattern, alternation, and reset while an access is in flight.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [1:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_re, m_we;
  logic [1:0]  m_width;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [31:0] mem [0:255];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_width(d_width), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_re(m_re), .m_we(m_we), .m_width(m_width), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  // Simple memory: word per low address byte, combinational read, write at the edge.
  assign m_rdata = m_re ? mem[m_addr[7:0]] : 32'h0;
  always @(posedge clk) if (m_we) mem[m_addr[7:0]] <= m_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_width = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic dreq(input logic we, input logic [1:0] w, input logic [31:0] a, input logic [31:0] wd);
    d_req = 1; d_we = we; d_width = w; d_addr = a; d_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit exp_i;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    rst = 1; idle();
    repeat (3) cyc();

    // Requests during reset must be ignored and all outputs quiet.
    i_req = 1; i_addr = 32'h10; dreq(0, 2, 32'h20, 0); #1;
    chk("rst_i_gnt", i_gnt, 0);  chk("rst_d_gnt", d_gnt, 0);
    chk("rst_m_re", m_re, 0);    chk("rst_m_addr", m_addr, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid, d_err}, 0);
    chk("rst_rdata", i_rdata | d_rdata, 0);

    // Lone fetch.
    cyc(); rst = 0; idle(); i_req = 1; i_addr = 32'h10; #1;
    chk("f_i_gnt", i_gnt, 1); chk("f_d_gnt", d_gnt, 0);
    cyc(); idle(); #1;
    chk("f_m_re", m_re, 1); chk("f_m_we", m_we, 0);
    chk("f_m_addr", m_addr, 32'h10); chk("f_m_width", m_width, 2);
    chk("f_early_rvalid", i_rvalid, 0);
    cyc(); #1;
    chk("f_i_rvalid", i_rvalid, 1); chk("f_i_rdata", i_rdata, 32'hA500_0010);
    chk("f_m_idle", {m_re, m_we, m_width}, 0); chk("f_m_addr0", m_addr, 0);
    cyc(); #1;
    chk("f_pulse", i_rvalid, 0);

    // Word write then read of the same address, back to back.
    cyc(); dreq(1, 2, 32'h1004, 32'hDEADBEEF); #1;
    chk("w_d_gnt", d_gnt, 1);
    cyc(); dreq(0, 2, 32'h1004, 0); #1;
    chk("r_d_gnt", d_gnt, 1); chk("w_m_we", m_we, 1); chk("w_m_re", m_re, 0);
    chk("w_m_addr", m_addr, 32'h1004); chk("w_m_wdata", m_wdata, 32'hDEADBEEF);
    cyc(); idle(); #1;
    chk("r_m_re", m_re, 1); chk("r_m_we", m_we, 0); chk("r_m_wdata", m_wdata, 0);
    chk("w_ack", d_rvalid, 1); chk("w_ack_rdata", d_rdata, 0); chk("w_ack_err", d_err, 0);
    cyc(); #1;
    chk("r_d_rvalid", d_rvalid, 1); chk("r_d_rdata", d_rdata, 32'hDEADBEEF);
    cyc(); #1;
    chk("r_pulse", d_rvalid, 0);

    // Misaligned half read.
    cyc(); dreq(0, 1, 32'h1001, 0); #1;
    chk("mh_d_gnt", d_gnt, 1);
    cyc(); idle(); #1;
    chk("mh_no_mem", {m_re, m_we}, 0); chk("mh_m_addr", m_addr, 0);
    cyc(); #1;
    chk("mh_rvalid", d_rvalid, 1); chk("mh_err", d_err, 1); chk("mh_rdata", d_rdata, 0);
    cyc(); #1;
    chk("mh_err_pulse", {d_rvalid, d_err}, 0);

    // Width 3 is always an error, even as a write.
    cyc(); dreq(1, 3, 32'h1000, 32'h1234); #1;
    chk("m3_d_gnt", d_gnt, 1);
    cyc(); idle(); #1;
    chk("m3_no_mem", {m_re, m_we}, 0); chk("m3_m_wdata", m_wdata, 0);
    cyc(); #1;
    chk("m3_err", {d_rvalid, d_err}, 2'b11);

    // Byte access at an odd address is legal.
    cyc(); dreq(0, 0, 32'h1003, 0); #1;
    chk("b_d_gnt", d_gnt, 1);
    cyc(); idle(); #1;
    chk("b_m_re", m_re, 1); chk("b_m_width", m_width, 0); chk("b_m_addr", m_addr, 32'h1003);
    cyc(); #1;
    chk("b_rvalid_err", {d_rvalid, d_err}, 2'b10); chk("b_rdata", d_rdata, 32'hA500_0003);

    // Both requesting for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 0) begin i_req = 1; i_addr = 32'h20; dreq(0, 2, 32'h30, 0); end
      #1;
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (k % 5 == 4);
`else
      exp_i = 1'b0;
`endif
      chk($sformatf("st_i_gnt%0d", k), i_gnt, exp_i);
      chk($sformatf("st_d_gnt%0d", k), d_gnt, !exp_i);
    end
    cyc(); idle();
    repeat (3) cyc();

    // Alternating fetch/data, one response per cycle in grant order.
    for (int k = 0; k < 8; k++) begin
      cyc(); idle();
      if (k < 6) begin
        if (k % 2 == 0) begin i_req = 1; i_addr = 32'h40 + 4 * k; end
        else dreq(0, 2, 32'h80 + 4 * k, 0);
      end
      #1;
      if (k < 6) begin
        chk($sformatf("alt_i_gnt%0d", k), i_gnt, (k % 2 == 0));
        chk($sformatf("alt_d_gnt%0d", k), d_gnt, (k % 2 == 1));
      end
      if (k >= 2) begin
        chk($sformatf("alt_i_rv%0d", k), i_rvalid, (k % 2 == 0));
        chk($sformatf("alt_d_rv%0d", k), d_rvalid, (k % 2 == 1));
        if (k % 2 == 0) chk($sformatf("alt_i_rd%0d", k), i_rdata, 32'hA500_0000 | (32'h40 + 4 * (k - 2)));
        else            chk($sformatf("alt_d_rd%0d", k), d_rdata, 32'hA500_0000 | (32'h80 + 4 * (k - 2)));
      end
    end

    // Reset the cycle after a data read grant: the access must vanish.
    cyc(); idle(); dreq(0, 2, 32'h1004, 0); #1;
    chk("rf_d_gnt", d_gnt, 1);
    cyc(); idle(); rst = 1; i_req = 1; i_addr = 32'h10; #1;
    chk("rf_m_re", m_re, 0); chk("rf_m_addr", m_addr, 0);
    chk("rf_i_gnt", i_gnt, 0); chk("rf_rvalid", d_rvalid, 0);
    cyc(); rst = 0; idle(); #1;
    chk("rf_no_rvalid", {d_rvalid, i_rvalid, d_err}, 0); chk("rf_m_idle", m_re, 0);
    cyc(); #1;
    chk("rf_no_rvalid2", d_rvalid, 0);
    i_req = 0;
    cyc(); i_req = 1; i_addr = 32'h10; #1;
    chk("rf_post_i_gnt", i_gnt, 1);
    cyc(); idle(); #1;
    chk("rf_post_m_re", m_re, 1);
    cyc(); #1;
    chk("rf_post_rdata", i_rdata, 32'hA500_0010);
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
